simple_dual_port_ram: RTL and testbench

SIMPLE_DUAL_PORT_RAM -- requirements
Module: simple_dual_port_ram

---
 rtl/simple_dual_port_ram_pkg.sv | 20 ++
 rtl/ram_clear_fsm.sv | 78 +++++++
 rtl/simple_dual_port_ram.sv | 128 ++++++++++++
 tb/tb_simple_dual_port_ram.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_dual_port_ram_pkg.sv
// Shared definitions for the simple dual-port RAM.
//   ram_state_e   : clear sequencer states (TEMIZLE = clearing, HAZIR = ready)
//   OKUMA_*       : values for the OKUMA_MODU parameter (collision behaviour)
//   CIKIS_*       : values for the CIKIS_REG parameter (read latency)
package simple_dual_port_ram_pkg;

    typedef enum logic {
        TEMIZLE = 1'b0,
        HAZIR   = 1'b1
    } ram_state_e;

    // Same-address read/write in one cycle: return the old word or the new one.
    localparam int OKUMA_READ_FIRST  = 0;
    localparam int OKUMA_WRITE_FIRST = 1;

    // Read data straight from the array register, or through one more register.
    localparam int CIKIS_TEK  = 0;
    localparam int CIKIS_CIFT = 1;

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer for simple_dual_port_ram.
// Walks a counter over every address, one per cycle, asking the top to write
// zero there. Reset and an accepted clear_req both restart the walk at 0.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   clear_req      : one-cycle request to zero the memory (ignored while clearing)
//   busy           : 1 in every clearing cycle
//   clear_addr     : address to zero this cycle
//   clear_we       : zero-write strobe for clear_addr
//   clear_start    : clear_req is being accepted this cycle
//   state_dbg      : current sequencer state
module ram_clear_fsm
    import simple_dual_port_ram_pkg::*;
#(
    parameter int addresGenisligi = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear_req,
    output logic                       busy,
    output logic [addresGenisligi-1:0] clear_addr,
    output logic                       clear_we,
    output logic                       clear_start,
    output ram_state_e                 state_dbg
);

    // One bit wider than the address so the terminal count (DERINLIK) is
    // representable and detected without wrapping back to zero.
    localparam logic [addresGenisligi:0] TERMINAL = {1'b1, {addresGenisligi{1'b0}}};

    ram_state_e                 state_q;
    ram_state_e                 state_d;
    logic [addresGenisligi:0]   cnt_q;
    logic [addresGenisligi:0]   cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TEMIZLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clear_start = 1'b0;
        case (state_q)
            TEMIZLE: begin
                cnt_d = cnt_q + 1'b1;
                // The last address is zeroed on the same edge that leaves TEMIZLE.
                if (cnt_d == TERMINAL) begin
                    state_d = HAZIR;
                    cnt_d   = '0;
                end
            end
            HAZIR: begin
                if (clear_req) begin
                    state_d     = TEMIZLE;
                    cnt_d       = '0;
                    clear_start = 1'b1;
                end
            end
            default: begin
                state_d = TEMIZLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy       = (state_q == TEMIZLE);
    assign clear_we   = busy;
    assign clear_addr = cnt_q[addresGenisligi-1:0];
    assign state_dbg  = state_q;

endmodule

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: one write port, one read port, one clock, with a
// built-in clear sequence that zeroes the whole array after reset or on request.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   clear_req             : one-cycle request to zero the memory
//   write_per, wr_addr, data_in : write port
//   rd_en, rd_addr        : read request
//   data_out, rd_valid    : registered read data and its qualifier
//   busy                  : clear in progress, user accesses ignored
//
// Read handshake: rd_en is a request with no back-pressure; it is taken on any
// edge where the block is ready (not busy and no clear being accepted). Each
// taken request produces exactly one rd_valid pulse 1 (CIKIS_REG=0) or 2
// (CIKIS_REG=1) cycles later, in order. data_out is only meaningful while
// rd_valid=1 and otherwise holds the last returned word.
module simple_dual_port_ram
    import simple_dual_port_ram_pkg::*;
#(
    parameter int veriGenisligi   = 8,
    parameter int addresGenisligi = 10,
    parameter int OKUMA_MODU      = OKUMA_READ_FIRST,
    parameter int CIKIS_REG       = CIKIS_TEK
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear_req,
    input  logic                       write_per,
    input  logic [addresGenisligi-1:0] wr_addr,
    input  logic [veriGenisligi-1:0]   data_in,
    input  logic                       rd_en,
    input  logic [addresGenisligi-1:0] rd_addr,
    output logic [veriGenisligi-1:0]   data_out,
    output logic                       rd_valid,
    output logic                       busy
);

    localparam int DERINLIK = 2 ** addresGenisligi;

    logic [veriGenisligi-1:0]   mem [DERINLIK];

    logic [addresGenisligi-1:0] clear_addr;
    logic                       clear_we;
    logic                       clear_start;
    ram_state_e                 ctrl_state;

    ram_clear_fsm #(
        .addresGenisligi(addresGenisligi)
    ) u_clear (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_addr (clear_addr),
        .clear_we   (clear_we),
        .clear_start(clear_start),
        .state_dbg  (ctrl_state)
    );

    // User traffic is only honoured in HAZIR, and not on the edge that
    // accepts a clear.
    logic user_ok;
    logic wr_fire;
    logic rd_fire;
    logic collide;

    assign user_ok = (ctrl_state == HAZIR) && !clear_start && !reset;
    assign wr_fire = user_ok && write_per;
    assign rd_fire = user_ok && rd_en;
    assign collide = write_per && (wr_addr == rd_addr);

    // Storage: no reset on the array; zeroing is done by the clear sequence.
    always_ff @(posedge clock) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= data_in;
        end
    end

    // First read stage. The array read returns the pre-edge contents, which
    // is the read-first result; write-first forwards data_in instead.
    logic                     rd_v1;
    logic [veriGenisligi-1:0] rd_d1;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_v1 <= 1'b0;
            rd_d1 <= '0;
        end else begin
            rd_v1 <= rd_fire;
            if (rd_fire) begin
                if (OKUMA_MODU == OKUMA_WRITE_FIRST && collide) begin
                    rd_d1 <= data_in;
                end else begin
                    rd_d1 <= mem[rd_addr];
                end
            end
        end
    end

    generate
        if (CIKIS_REG == CIKIS_CIFT) begin : g_out_reg
            logic                     rd_v2;
            logic [veriGenisligi-1:0] rd_d2;

            // Not gated by busy: reads already in flight finish with their
            // pre-clear data.
            always_ff @(posedge clock) begin
                if (reset) begin
                    rd_v2 <= 1'b0;
                    rd_d2 <= '0;
                end else begin
                    rd_v2 <= rd_v1;
                    if (rd_v1) begin
                        rd_d2 <= rd_d1;
                    end
                end
            end

            assign data_out = rd_d2;
            assign rd_valid = rd_v2;
        end else begin : g_out_direct
            assign data_out = rd_d1;
            assign rd_valid = rd_v1;
        end
    endgenerate

endmodule

// File: tb/tb_simple_dual_port_ram.sv
module tb_simple_dual_port_ram;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  // Two DUT configurations driven by the same stimulus.
  localparam int OM0 = 0;
  localparam int CR0 = 0;
  localparam int OM1 = 1;
  localparam int CR1 = 1;

  // ---------------- clock / reset / signals ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          clear_req;
  logic          write_per;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] dout0, dout1;
  logic          v0, v1, b0, b1;

  simple_dual_port_ram #(
    .veriGenisligi(DW), .addresGenisligi(AW), .OKUMA_MODU(OM0), .CIKIS_REG(CR0)
  ) dut0 (
    .clock(clock), .reset(reset), .clear_req(clear_req), .write_per(write_per),
    .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
    .data_out(dout0), .rd_valid(v0), .busy(b0)
  );

  simple_dual_port_ram #(
    .veriGenisligi(DW), .addresGenisligi(AW), .OKUMA_MODU(OM1), .CIKIS_REG(CR1)
  ) dut1 (
    .clock(clock), .reset(reset), .clear_req(clear_req), .write_per(write_per),
    .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en), .rd_addr(rd_addr),
    .data_out(dout1), .rd_valid(v1), .busy(b1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } pend_t;

  logic [DW-1:0] ref_mem [DEPTH];
  int            busy_left  = DEPTH;
  int            cyc        = 0;
  bit            model_live = 0;
  pend_t         exp_q0[$];
  pend_t         exp_q1[$];
  logic          exp_v0 = 1'b0, exp_v1 = 1'b0;
  logic [DW-1:0] exp_d0 = '0, exp_d1 = '0;

  // One clock edge of the abstract RAM: a clear takes DEPTH edges zeroing
  // addresses in order; otherwise reads see the array before this edge's write.
  task automatic model_step();
    logic [DW-1:0] rv;
    pend_t         pv;
    cyc++;
    if (reset) begin
      busy_left = DEPTH;
      exp_q0.delete();
      exp_q1.delete();
      exp_v0 = 1'b0; exp_v1 = 1'b0;
      exp_d0 = '0;   exp_d1 = '0;
    end else begin
      if (busy_left > 0) begin
        ref_mem[DEPTH - busy_left] = '0;
        busy_left--;
      end else if (clear_req) begin
        busy_left = DEPTH;
      end else begin
        if (rd_en) begin
          rv = (OM0 == 1 && write_per && wr_addr == rd_addr) ? data_in : ref_mem[rd_addr];
          exp_q0.push_back('{due: cyc + CR0, d: rv});
          rv = (OM1 == 1 && write_per && wr_addr == rd_addr) ? data_in : ref_mem[rd_addr];
          exp_q1.push_back('{due: cyc + CR1, d: rv});
        end
        if (write_per) ref_mem[wr_addr] = data_in;
      end
      exp_v0 = 1'b0;
      if (exp_q0.size() > 0 && exp_q0[0].due == cyc) begin
        pv = exp_q0.pop_front();
        exp_v0 = 1'b1;
        exp_d0 = pv.d;
      end
      exp_v1 = 1'b0;
      if (exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
        pv = exp_q1.pop_front();
        exp_v1 = 1'b1;
        exp_d1 = pv.d;
      end
    end
    model_live = 1;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  // Compare process: every cycle, all outputs of both DUTs.
  initial begin
    forever begin
      @(negedge clock);
      if (model_live) begin
        check("busy0",  b0,    busy_left > 0);
        check("busy1",  b1,    busy_left > 0);
        check("valid0", v0,    exp_v0);
        check("valid1", v1,    exp_v1);
        check("data0",  dout0, exp_d0);
        check("data1",  dout1, exp_d1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    write_per = 1'b0;
    rd_en     = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_write(input int a, input int d);
    write_per = 1'b1;
    wr_addr   = AW'(a);
    data_in   = DW'(d);
    step();
    write_per = 1'b0;
  endtask

  // Counts cycles with busy high starting at the current negedge (bounded).
  task automatic count_busy(output int n, output int bad_valid);
    n = 0;
    bad_valid = 0;
    while (b0 && n < 64) begin
      if (v0 || v1) bad_valid++;
      n++;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, bad;
    reset = 1'b1;
    idle();
    wr_addr = '0;
    rd_addr = '0;
    data_in = '0;
    step(3);

    // Reset values, then the initial clear.
    check("rst_busy",  b0,    1);
    check("rst_valid", v1,    0);
    check("rst_data",  dout0, 0);
    reset = 1'b0;
    count_busy(n, bad);
    check("init_busy_len", n, 16);

    // Every address reads zero after the initial clear.
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      step();
      check("zero_rd_v", v0, 1);
      check("zero_rd_d", dout0, 0);
    end
    rd_en = 1'b0;
    step(2);

    // Write 0xA5 to 3, read it back at both latencies.
    do_write(3, 'hA5);
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    rd_en = 1'b0;
    check("a5_v0", v0, 1);
    check("a5_d0", dout0, 'hA5);
    check("a5_v1_early", v1, 0);
    step();
    check("a5_v1", v1, 1);
    check("a5_d1", dout1, 'hA5);

    // Same-address collision: old word vs new word.
    do_write(7, 'h11);
    write_per = 1'b1; wr_addr = 4'd7; data_in = 8'h22;
    rd_en = 1'b1; rd_addr = 4'd7;
    step();
    idle();
    check("col_d0", dout0, 'h11);
    step();
    check("col_d1", dout1, 'h22);
    rd_en = 1'b1; rd_addr = 4'd7;
    step();
    rd_en = 1'b0;
    check("col_after_d0", dout0, 'h22);
    step();
    check("col_after_d1", dout1, 'h22);

    // Fill with address value, then a fully pipelined sweep.
    for (int i = 0; i < DEPTH; i++) do_write(i, i);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      step();
      check("sweep_v0", v0, 1);
      check("sweep_d0", dout0, i);
      if (i > 0) begin
        check("sweep_v1", v1, 1);
        check("sweep_d1", dout1, i - 1);
      end
    end
    rd_en = 1'b0;
    step(3);

    // Clear request with user traffic during busy.
    clear_req = 1'b1;
    write_per = 1'b1; wr_addr = 4'd15; data_in = 8'hFF;
    rd_en = 1'b1; rd_addr = 4'd5;
    step();
    clear_req = 1'b0;
    count_busy(n, bad);
    idle();
    check("clr_busy_len", n, 16);
    check("clr_no_valid", bad, 0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      step();
      check("clr_rd_d0", dout0, 0);
    end
    rd_en = 1'b0;
    step(2);

    // Reset in the middle of a clear; data_out must go to zero.
    do_write(3, 'h5C);
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    rd_en = 1'b0;
    step(2);
    check("pre_rst_d0", dout0, 'h5C);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step(8);
    reset = 1'b1;
    step();
    check("mid_rst_d0", dout0, 0);
    check("mid_rst_d1", dout1, 0);
    check("mid_rst_v0", v0, 0);
    step();
    reset = 1'b0;
    count_busy(n, bad);
    check("rst_busy_len", n, 16);

    // Randomized traffic with occasional clears and resets.
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 299) == 0);
      clear_req = ($urandom_range(0, 49) == 0);
      write_per = 1'($urandom_range(0, 1));
      rd_en     = 1'($urandom_range(0, 1));
      wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      data_in   = DW'($urandom_range(0, 255));
      rd_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      step();
    end
    reset = 1'b0;
    idle();
    step(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
